stopwatch_control: RTL and testbench
====================================

STOPWATCH_CONTROL -- requirements
Module: stopwatch_control

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500_000, number of consecutive stable cycles (10 ms at 50 MHz) required to accept a key level; legal range 2..2^20-1.
REQ-002 SHALL have parameter CNT_SIZE, default 20, width of each debounce counter.
REQ-003 SHALL have port inputClock, input, 1, single clock for all state; all flops update on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port nStartStopKey, input, 1, raw asynchronous push-button, low while pressed.
REQ-006 SHALL have port nClearKey, input, 1, raw asynchronous push-button, low while pressed.
REQ-007 SHALL have port nLapKey, input, 1, raw asynchronous push-button, low while pressed.
REQ-008 SHALL have port pause, output, 1, high when the timer counter chain must hold.
REQ-009 SHALL have port nCounterReset, output, 1, active-low one-cycle clear to the counter chain.
REQ-010 SHALL have port lapHold, output, 1, high while the display must show the frozen lap value.
REQ-011 SHALL have port state, output, 2, current FSM state encoding.

Function
REQ-012 SHALL pass each raw key through a 2-flop synchronizer before any other logic.
REQ-013 SHALL keep, per key, a debounced level and a CNT_SIZE-bit counter: counter cleared when synchronized value equals debounced level; otherwise incremented; when counter = DEBOUNCE_CYCLES-1 and values still differ, debounced level takes synchronized value and counter clears.
REQ-014 SHALL generate a one-cycle press event on each debounced 1->0 transition; releases generate no event; a held key generates exactly one event.
REQ-015 SHALL implement FSM states IDLE=2'b00, RUNNING=2'b01, STOPPED=2'b10, LAP=2'b11.
REQ-016 SHALL transition IDLE -> RUNNING on start/stop event; ignore clear and lap in IDLE.
REQ-017 SHALL transition RUNNING -> STOPPED on start/stop event, RUNNING -> LAP on lap event; ignore clear in RUNNING.
REQ-018 SHALL transition LAP -> RUNNING on lap event, LAP -> STOPPED on start/stop event; ignore clear in LAP.
REQ-019 SHALL transition STOPPED -> RUNNING on start/stop event, STOPPED -> IDLE on clear event; ignore lap in STOPPED.
REQ-020 SHALL, when events coincide in one cycle, act on only one, priority clear > start/stop > lap, and discard the others.
REQ-021 SHALL register all outputs; state, pause, lapHold reflect the new state in the cycle after the event pulse.
REQ-022 SHALL drive pause = 1 in IDLE and STOPPED, 0 in RUNNING and LAP.
REQ-023 SHALL drive lapHold = 1 only in LAP.
REQ-024 SHALL drive nCounterReset = 0 for exactly one cycle, coincident with the first cycle state = IDLE after a STOPPED -> IDLE transition; 1 otherwise.
REQ-025 SHALL have total latency from raw key edge to output change of 2 (sync) + DEBOUNCE_CYCLES + 1 (event) + 1 (output) cycles, within ±1 cycle.
REQ-026 SHALL reject any glitch shorter than DEBOUNCE_CYCLES synchronized cycles with no event and no output change.

Reset
REQ-027 SHALL, while reset = 1, force state = IDLE, pause = 1, lapHold = 0, nCounterReset = 0, debounced levels = 1, debounce counters = 0, synchronizer flops = 1, no events.
REQ-028 SHALL drive nCounterReset = 1 from the first cycle after reset deasserts; a key held low through reset release SHALL produce one press event after debounce.
REQ-029 SHALL, on reset asserted mid-operation (any state, counter mid-count), reach REQ-027 values on the next clock edge.

Verification (DEBOUNCE_CYCLES = 4)
REQ-030 SHALL cover: reset, press nStartStopKey low 10 cycles -> state 00->01, pause 1->0 at 2+4+1+1 cycles after press edge.
REQ-031 SHALL cover: in RUNNING, nLapKey low 3 cycles then high -> no event, state stays 01, lapHold stays 0.
REQ-032 SHALL cover: RUNNING, lap press -> state 11, lapHold 1, pause 0; second lap press -> state 01, lapHold 0.
REQ-033 SHALL cover: STOPPED, nClearKey and nStartStopKey pressed same cycle -> state 00, nCounterReset low exactly 1 cycle, no RUNNING entry.
REQ-034 SHALL cover: RUNNING, clear press -> state stays 01, nCounterReset stays 1; key held 100 cycles after start/stop press -> exactly one transition.
REQ-035 SHALL cover: reset asserted 2 cycles into a debounce count from LAP -> next edge state 00, pause 1, lapHold 0, nCounterReset 0.

Source files
------------

// File: rtl/stopwatch_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_control_if
//  Description : Key inputs and control outputs of the stopwatch controller.
//                The master side owns the raw push-buttons and observes the
//                control outputs; the slave side is the controller itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stopwatch_control_if;
    logic       nStartStopKey;
    logic       nClearKey;
    logic       nLapKey;
    logic       pause;
    logic       nCounterReset;
    logic       lapHold;
    logic [1:0] state;

    modport master (
        output nStartStopKey, nClearKey, nLapKey,
        input  pause, nCounterReset, lapHold, state
    );

    modport slave (
        input  nStartStopKey, nClearKey, nLapKey,
        output pause, nCounterReset, lapHold, state
    );
endinterface
`default_nettype wire

// File: rtl/stopwatch_control.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_control
//  Description : Debounces three active-low push-buttons, turns each debounced
//                press into a one-cycle event and runs the stopwatch mode FSM
//                (IDLE / RUNNING / STOPPED / LAP) that drives pause, lapHold
//                and the one-cycle counter clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_control #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int CNT_SIZE        = 20
) (
    input  wire logic           inputClock,
    input  wire logic           reset,
    stopwatch_control_if.slave  sw
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUNNING = 2'b01,
        S_STOPPED = 2'b10,
        S_LAP     = 2'b11
    } state_t;

    // Key slot indices inside the per-key vectors
    localparam int c_key_ss  = 0;
    localparam int c_key_clr = 1;
    localparam int c_key_lap = 2;

    localparam logic [CNT_SIZE-1:0] c_cnt_max = CNT_SIZE'(DEBOUNCE_CYCLES - 1);

    logic [2:0]          w_raw;
    logic [2:0]          r_sync1;
    logic [2:0]          r_sync2;
    logic [2:0]          r_level;
    logic [2:0]          r_level_d;
    logic [2:0]          r_press;
    logic [CNT_SIZE-1:0] r_cnt [3];
    logic [2:0]          w_sel;

    state_t r_state;
    state_t w_state_next;
    logic   r_pause;
    logic   r_lap_hold;
    logic   r_n_counter_reset;

    assign w_raw = {sw.nLapKey, sw.nClearKey, sw.nStartStopKey};

    // Two-flop synchronizers; idle level of an unpressed key is 1
    always_ff @(posedge inputClock) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Per-key debounce counter, debounced level and registered 1->0 press event
    always_ff @(posedge inputClock) begin
        if (reset) begin
            r_level   <= '1;
            r_level_d <= '1;
            r_press   <= '0;
            for (int k = 0; k < 3; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_level_d <= r_level;
            r_press   <= r_level_d & ~r_level;
            for (int k = 0; k < 3; k++) begin
                if (r_sync2[k] == r_level[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == c_cnt_max) begin
                    r_level[k] <= r_sync2[k];
                    r_cnt[k]   <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + CNT_SIZE'(1);
                end
            end
        end
    end

    // Coincident events: keep only the highest priority one (clear > start/stop > lap).
    // A winning event that the current state ignores still swallows the others.
    always_comb begin
        w_sel = '0;
        if (r_press[c_key_clr]) begin
            w_sel[c_key_clr] = 1'b1;
        end else if (r_press[c_key_ss]) begin
            w_sel[c_key_ss] = 1'b1;
        end else if (r_press[c_key_lap]) begin
            w_sel[c_key_lap] = 1'b1;
        end
    end

    // Mode FSM next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_sel[c_key_ss]) w_state_next = S_RUNNING;
            end
            S_RUNNING: begin
                if (w_sel[c_key_ss])       w_state_next = S_STOPPED;
                else if (w_sel[c_key_lap]) w_state_next = S_LAP;
            end
            S_LAP: begin
                if (w_sel[c_key_ss])       w_state_next = S_STOPPED;
                else if (w_sel[c_key_lap]) w_state_next = S_RUNNING;
            end
            S_STOPPED: begin
                if (w_sel[c_key_clr])     w_state_next = S_IDLE;
                else if (w_sel[c_key_ss]) w_state_next = S_RUNNING;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register with registered outputs decoded from the next state
    always_ff @(posedge inputClock) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_pause           <= 1'b1;
            r_lap_hold        <= 1'b0;
            r_n_counter_reset <= 1'b0;
        end else begin
            r_state           <= w_state_next;
            r_pause           <= (w_state_next == S_IDLE) || (w_state_next == S_STOPPED);
            r_lap_hold        <= (w_state_next == S_LAP);
            r_n_counter_reset <= !((r_state == S_STOPPED) && (w_state_next == S_IDLE));
        end
    end

    assign sw.state         = r_state;
    assign sw.pause         = r_pause;
    assign sw.lapHold       = r_lap_hold;
    assign sw.nCounterReset = r_n_counter_reset;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_control
//  Description : Self-checking bench for stopwatch_control with a short
//                debounce. Expected output snapshots are queued with the
//                cycle they are due and compared when that cycle arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_control;

    localparam int DEB = 4;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_STOP = 2'b10;
    localparam logic [1:0] ST_LAP  = 2'b11;

    localparam logic [2:0] K_SS  = 3'b001;
    localparam logic [2:0] K_CLR = 3'b010;
    localparam logic [2:0] K_LAP = 3'b100;

    typedef struct {
        string      tag;
        int         at;
        logic [4:0] val;   // {state, pause, lapHold, nCounterReset}
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [1:0] m_state = ST_IDLE;
    exp_t       sb[$];

    stopwatch_control_if sw_if();

    stopwatch_control #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_SIZE        (20)
    ) dut (
        .inputClock (clk),
        .reset      (rst),
        .sw         (sw_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Queue an expected output snapshot; pause/lapHold follow from the state
    task automatic expect_at(input string tag, input int at, input logic [1:0] st, input logic ncr);
        exp_t e;
        int   i;
        e.tag = tag;
        e.at  = at;
        e.val = {st, (st == ST_IDLE) || (st == ST_STOP), (st == ST_LAP), ncr};
        i = 0;
        while (i < sb.size() && sb[i].at <= at) i++;
        sb.insert(i, e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_keys(input logic [2:0] mask, input logic v);
        if (mask[0]) sw_if.nStartStopKey = v;
        if (mask[1]) sw_if.nClearKey     = v;
        if (mask[2]) sw_if.nLapKey       = v;
    endtask

    // Press the masked keys for 'hold' cycles; the new state is due 8 cycles
    // after the press (2 sync + DEB debounce + 1 event + 1 output).
    task automatic press(input string tag, input logic [2:0] mask, input int hold,
                         input logic [1:0] nxt, input logic ncr_pulse);
        int n;
        n = cyc;
        expect_at({tag, "_pre"}, n + 7, m_state, 1'b1);
        if (ncr_pulse) begin
            expect_at(tag, n + 8, nxt, 1'b0);
            expect_at({tag, "_ncr_end"}, n + 9, nxt, 1'b1);
        end else begin
            expect_at(tag, n + 8, nxt, 1'b1);
        end
        expect_at({tag, "_after"}, n + hold + 10, nxt, 1'b1);
        set_keys(mask, 1'b0);
        tick(hold);
        set_keys(mask, 1'b1);
        tick(12);
        m_state = nxt;
    endtask

    // Compare every snapshot that has come due
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check(e.tag, {27'd0, sw_if.state, sw_if.pause, sw_if.lapHold, sw_if.nCounterReset},
                  {27'd0, e.val});
        end
    end

    // Stimulus sequence
    initial begin
        int n;
        int r;
        set_keys(3'b111, 1'b1);
        rst = 1'b1;
        expect_at("reset_state", 2, ST_IDLE, 1'b0);
        tick(3);
        rst = 1'b0;
        expect_at("post_reset_ncr", cyc + 1, ST_IDLE, 1'b1);
        tick(4);

        press("start", K_SS, 10, ST_RUN, 1'b0);

        // Lap glitch shorter than the debounce window
        n = cyc;
        expect_at("lap_glitch_a", n + 8, ST_RUN, 1'b1);
        expect_at("lap_glitch_b", n + 14, ST_RUN, 1'b1);
        set_keys(K_LAP, 1'b0);
        tick(3);
        set_keys(K_LAP, 1'b1);
        tick(16);

        press("lap1",            K_LAP,          8,   ST_LAP,  1'b0);
        press("lap2",            K_LAP,          8,   ST_RUN,  1'b0);
        press("clear_in_run",    K_CLR,          8,   ST_RUN,  1'b0);
        press("start_held",      K_SS,           100, ST_STOP, 1'b0);
        press("lap_in_stop",     K_LAP,          8,   ST_STOP, 1'b0);
        press("restart",         K_SS,           8,   ST_RUN,  1'b0);
        press("lap3",            K_LAP,          8,   ST_LAP,  1'b0);
        press("stop_from_lap",   K_SS,           8,   ST_STOP, 1'b0);
        press("clear_and_start", K_CLR | K_SS,   8,   ST_IDLE, 1'b1);
        press("clear_in_idle",   K_CLR,          8,   ST_IDLE, 1'b0);
        press("lap_in_idle",     K_LAP,          8,   ST_IDLE, 1'b0);
        press("start2",          K_SS,           8,   ST_RUN,  1'b0);
        press("lap4",            K_LAP,          8,   ST_LAP,  1'b0);

        // Reset two cycles into a start/stop debounce count while in LAP;
        // the key stays held through reset release and must fire once.
        n = cyc;
        expect_at("lap_before_reset", n + 4, ST_LAP, 1'b1);
        expect_at("reset_mid", n + 5, ST_IDLE, 1'b0);
        expect_at("reset_mid_hold", n + 6, ST_IDLE, 1'b0);
        set_keys(K_SS, 1'b0);
        tick(4);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        m_state = ST_IDLE;
        r = cyc;
        expect_at("ncr_after_reset", r + 1, ST_IDLE, 1'b1);
        expect_at("held_pre", r + 7, ST_IDLE, 1'b1);
        expect_at("held_through_reset", r + 8, ST_RUN, 1'b1);
        expect_at("held_once", r + 20, ST_RUN, 1'b1);
        tick(10);
        set_keys(K_SS, 1'b1);
        tick(12);
        m_state = ST_RUN;

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
`default_nettype wire
